// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and lane helpers for the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_t;
  typedef enum logic [2:0] {ST_IDLE, ST_RD_ISSUE, ST_RD_WAIT, ST_WR_ISSUE, ST_RESP} lsu_state_t;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
  function automatic size_t eff_size(size_t s);
    return s == SZ_RSVD ? SZ_WORD : s;
  endfunction
  function automatic logic [1:0] align_lane(size_t s, logic [1:0] a);
    return s == SZ_BYTE ? a : s == SZ_HALF ? {a[1], 1'b0} : 2'b00;
  endfunction
  function automatic logic [4:0] lane_shift(size_t s, logic [1:0] lane);
    return s == SZ_BYTE ? {lane, 3'b000} : s == SZ_HALF ? {lane[1], 4'b0000} : 5'd0;
  endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: CPU request/response and data RAM signals; master = LSU side, slave = CPU+RAM side.
interface lsu_mem_master_if #(parameter int MEM_ADDR_WIDTH = 10) ();
  import lsu_pkg::*;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  size_t                     req_size;
  logic                      req_unsigned;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [31:0]               resp_rdata;
  logic                      resp_err;
  logic [MEM_ADDR_WIDTH-1:0] mem_address;
  logic [31:0]               mem_data_in;
  logic                      mem_write;
  logic                      mem_read;
  logic [31:0]               mem_data_out;
  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data_in, mem_write, mem_read
  );
  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data_in, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_data_align.sv
// lsu_data_align: extracts and extends load lanes, merges store lanes into a RAM word.
module lsu_data_align
  import lsu_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  always_comb begin
    sh        = lane_shift(size, lane);
    shifted   = rword >> sh;
    mask      = (size == SZ_BYTE ? BYTE_MASK : size == SZ_HALF ? HALF_MASK : '1) << sh;
    load_data = size == SZ_BYTE ? {{24{shifted[7] & ~uns}}, shifted[7:0]} :
                size == SZ_HALF ? {{16{shifted[15] & ~uns}}, shifted[15:0]} : rword;
    merged    = (rword & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for a 1-cycle registered-read RAM, sub-word stores via read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input logic              clk,
  input logic              rst,
  lsu_mem_master_if.master bus
);
  lsu_state_t                state_q, state_d;
  logic                      write_q, write_d;
  size_t                     size_q, size_d;
  logic                      uns_q, uns_d;
  logic [1:0]                lane_q, lane_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     mem_data_in_q, mem_data_in_d;
  logic [DATA_WIDTH-1:0]     resp_rdata_q, resp_rdata_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                      resp_err_q, resp_err_d;
  logic                      accept;
  logic                      trap;
  size_t                     req_sz;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [DATA_WIDTH-1:0]     merged;

  assign accept = bus.req_valid && state_q == ST_IDLE;
  assign req_sz = eff_size(bus.req_size);
`ifdef MISALIGN_TRAP_EN
  assign trap = (req_sz == SZ_HALF && bus.req_addr[0]) || (req_sz == SZ_WORD && bus.req_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  lsu_data_align u_align (
    .size      (size_q),
    .lane      (lane_q),
    .uns       (uns_q),
    .rword     (bus.mem_data_out),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = !accept ? ST_IDLE : trap ? ST_RESP :
                             (bus.req_write && req_sz == SZ_WORD) ? ST_WR_ISSUE : ST_RD_ISSUE;
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  state_d = write_q ? ST_WR_ISSUE : ST_RESP;
      ST_WR_ISSUE: state_d = ST_RESP;
      ST_RESP:     state_d = bus.resp_ready ? ST_IDLE : ST_RESP;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = state_q == ST_IDLE;
    bus.resp_valid  = state_q == ST_RESP;
    bus.mem_read    = state_q == ST_RD_ISSUE;
    bus.mem_write   = state_q == ST_WR_ISSUE;
    bus.mem_address = mem_address_q;
    bus.mem_data_in = mem_data_in_q;
    bus.resp_rdata  = resp_rdata_q;
    bus.resp_err    = resp_err_q;
  end

  // Request fields are captured once at accept; RD_WAIT fills either the load result or the merged store word.
  always_comb begin
    write_d       = write_q;
    size_d        = size_q;
    uns_d         = uns_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    if (accept) begin
      write_d       = bus.req_write;
      size_d        = req_sz;
      uns_d         = bus.req_unsigned;
      lane_d        = align_lane(req_sz, bus.req_addr[1:0]);
      wdata_d       = bus.req_wdata;
      mem_address_d = bus.req_addr[MEM_ADDR_WIDTH+1:2];
      mem_data_in_d = bus.req_write ? bus.req_wdata : mem_data_in_q;
      resp_rdata_d  = '0;
      resp_err_d    = trap;
    end else if (state_q == ST_RD_WAIT) begin
      mem_data_in_d = write_q ? merged : mem_data_in_q;
      resp_rdata_d  = write_q ? '0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q       <= 1'b0;
      size_q        <= SZ_BYTE;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      write_q       <= write_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed vector table plus backpressure and mid-operation reset sequences.
module tb_lsu_mem_master;
  import lsu_pkg::*;
`ifdef MISALIGN_TRAP_EN
  localparam bit T = 1'b1;
`else
  localparam bit T = 1'b0;
`endif
  typedef struct {
    logic        wr;
    size_t       sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [9:0]  last_raddr = '0;
  logic [9:0]  last_waddr = '0;
  logic [31:0] ram [1024];
  logic [31:0] rd_q = '0;
  vec_t vecs[$];

  lsu_mem_master_if #(.MEM_ADDR_WIDTH(10)) bus ();
  lsu_mem_master #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.mem_data_out = rd_q;

  always @(posedge clk) begin
    if (bus.mem_write) begin
      ram[bus.mem_address] <= bus.mem_data_in;
      wr_cnt <= wr_cnt + 1;
      last_waddr <= bus.mem_address;
    end
    if (bus.mem_read) begin
      rd_q <= ram[bus.mem_address];
      rd_cnt <= rd_cnt + 1;
      last_raddr <= bus.mem_address;
    end
    if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({p, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({p, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({p, "_resp_err"}, {31'd0, bus.resp_err}, 32'd0);
    chk({p, "_mem_read"}, {31'd0, bus.mem_read}, 32'd0);
    chk({p, "_mem_write"}, {31'd0, bus.mem_write}, 32'd0);
    chk({p, "_mem_address"}, {22'd0, bus.mem_address}, 32'd0);
    chk({p, "_mem_data_in"}, bus.mem_data_in, 32'd0);
  endtask

  function automatic vec_t mk(input logic wr, input size_t sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic err, input int lat, input int nrd, input int nwr);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_err = err; v.exp_lat = lat; v.exp_rd = nrd; v.exp_wr = nwr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_size = v.sz;
    bus.req_unsigned = v.uns;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
  endtask

  task automatic run(input vec_t v, input string n);
    int r0, w0, lat;
    @(negedge clk);
    chk({n, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    drive(v);
    bus.resp_ready = 1'b1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({n, "_lat"}, lat, v.exp_lat);
    chk({n, "_rdata"}, bus.resp_rdata, v.exp_rdata);
    chk({n, "_err"}, {31'd0, bus.resp_err}, {31'd0, v.exp_err});
    @(posedge clk);
    #1;
    chk({n, "_nrd"}, rd_cnt - r0, v.exp_rd);
    chk({n, "_nwr"}, wr_cnt - w0, v.exp_wr);
    if (v.exp_wr > 0) chk({n, "_waddr"}, {22'd0, last_waddr}, {22'd0, v.addr[11:2]});
    if (v.exp_rd > 0) chk({n, "_raddr"}, {22'd0, last_raddr}, {22'd0, v.addr[11:2]});
  endtask

  initial begin
    int r0, w0, lat;
    logic [31:0] held;
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'h8081F2F3, 32'h0, 0, 2, 0, 1));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h12, 32'h0, 32'hFFFFFF81, 0, 3, 1, 0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h12, 32'h0, 32'h00000081, 0, 3, 1, 0));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h12, 32'h0, 32'hFFFF8081, 0, 3, 1, 0));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h10, 32'h0, 32'h0000F2F3, 0, 3, 1, 0));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, 0, 1));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h11, 32'h123456AA, 32'h0, 0, 4, 1, 1));
    vecs.push_back(mk(0, SZ_WORD, 1, 32'h10, 32'h0, 32'h1122AA44, 0, 3, 1, 0));
    vecs.push_back(mk(1, SZ_HALF, 0, 32'h12, 32'h0000BEEF, 32'h0, 0, 4, 1, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hBEEFAA44, 0, 3, 1, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h13, 32'h0, T ? 32'h0 : 32'hBEEFAA44, T, T ? 1 : 3, T ? 0 : 1, 0));
    vecs.push_back(mk(0, SZ_RSVD, 0, 32'h10, 32'h0, 32'hBEEFAA44, 0, 3, 1, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h1010, 32'h0, 32'hBEEFAA44, 0, 3, 1, 0));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h11, 32'h0, T ? 32'h0 : 32'hFFFFAA44, T, T ? 1 : 3, T ? 0 : 1, 0));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h12, 32'h0BADF00D, 32'h0, T, T ? 1 : 2, 0, T ? 0 : 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0, T ? 32'hBEEFAA44 : 32'h0BADF00D, 0, 3, 1, 0));

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) rst = 1'b1;

    foreach (vecs[i]) run(vecs[i], $sformatf("v%0d", i));

    // Backpressure: response held 5 cycles while a second request waits.
    @(negedge clk);
    drive(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0));
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #1 drive(mk(0, SZ_BYTE, 1, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0));
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp_lat", lat, 3);
    held = bus.resp_rdata;
    chk("bp_rdata", held, T ? 32'hBEEFAA44 : 32'h0BADF00D);
    r0 = rd_cnt;
    w0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", k), {31'd0, bus.resp_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rdata", k), bus.resp_rdata, held);
      chk($sformatf("bp_hold%0d_ready", k), {31'd0, bus.req_ready}, 32'd0);
      chk($sformatf("bp_hold%0d_strobes", k), (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("bp_next_accepted", {31'd0, bus.req_ready}, 32'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp_next_rdata", bus.resp_rdata, T ? 32'h00000044 : 32'h0000000D);
    @(posedge clk);

    // Reset asserted during RD_WAIT of a byte store must drop the write.
    run(mk(1, SZ_WORD, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, 0, 1), "rm_init");
    @(negedge clk);
    drive(mk(1, SZ_BYTE, 0, 32'h11, 32'h00000055, 32'h0, 0, 0, 0, 0));
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 w0 = wr_cnt;
    rst = 1'b0;
    #1 chk_reset("rm");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rm_no_write", wr_cnt - w0, 32'd0);
    chk("rm_ram_word", ram[4], 32'h11223344);
    run(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'h11223344, 0, 3, 1, 0), "rm_reload");

    chk("strobe_overlap", both_cnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
